instr_fetch: RTL and testbench

//  Fetch stage feeding the decode/control path: owns the PC, issues one instruction-memory

---
 rtl/instr_fetch_if.sv | 25 ++
 rtl/instr_fetch.sv | 118 +++++++++++
 tb/tb_instr_fetch.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// Instruction-memory request/response bus between the fetch stage and instruction memory.
// master: fetch side, slave: memory side.
interface instr_fetch_if;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic        ImemGnt;
    logic        ImemRValid;
    logic [31:0] ImemRData;

    modport master (
        output ImemReq,
        output ImemAddr,
        input  ImemGnt,
        input  ImemRValid,
        input  ImemRData
    );

    modport slave (
        input  ImemReq,
        input  ImemAddr,
        output ImemGnt,
        output ImemRValid,
        output ImemRData
    );
endinterface

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, issues one instruction-memory request at a time and
// holds the fetched word for decode until it retires.
module instr_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 PCSrc,
    input  logic [31:0]          PCTarget,
    input  logic                 Stall,
    input  logic                 Flush,
    input  logic [31:0]          FlushPC,
    instr_fetch_if.master        imem,
    output logic [31:0]          PC,
    output logic [31:0]          PCPlus4,
    output logic [31:0]          Instr,
    output logic                 InstrValid
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2
    } state_t;

    state_t      state, nstate;
    logic [31:0] pc_q, npc;
    logic [31:0] instr_q, ninstr;
    logic        valid_q, nvalid;
    logic        kill_q, nkill;
    logic        req_q;

    assign PC            = pc_q;
    assign PCPlus4       = pc_q + 32'd4;
    assign Instr         = instr_q;
    assign InstrValid    = valid_q;
    assign imem.ImemReq  = req_q;
    assign imem.ImemAddr = pc_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= FETCH;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
            kill_q  <= 1'b0;
            req_q   <= 1'b1;
        end else begin
            state   <= nstate;
            pc_q    <= npc;
            instr_q <= ninstr;
            valid_q <= nvalid;
            kill_q  <= nkill;
            req_q   <= (nstate == FETCH);
        end
    end

    always_comb begin
        nstate = state;
        npc    = pc_q;
        ninstr = instr_q;
        nvalid = valid_q;
        nkill  = kill_q;

        if (Flush) begin
            npc    = FlushPC & 32'hFFFF_FFFC;
            ninstr = NOP_INSTR;
            nvalid = 1'b0;
            // An accepted or in-flight request must still be drained; Kill marks its data as stale.
            case (state)
                FETCH: begin
                    if (imem.ImemGnt) begin
                        nstate = WAIT;
                        nkill  = 1'b1;
                    end
                end
                WAIT: begin
                    if (imem.ImemRValid) begin
                        nstate = FETCH;
                        nkill  = 1'b0;
                    end else begin
                        nkill  = 1'b1;
                    end
                end
                default: nstate = FETCH;
            endcase
        end else begin
            case (state)
                FETCH: begin
                    if (imem.ImemGnt) nstate = WAIT;
                end
                WAIT: begin
                    if (imem.ImemRValid) begin
                        if (kill_q) begin
                            nkill  = 1'b0;
                            nstate = FETCH;
                        end else begin
                            ninstr = imem.ImemRData;
                            nvalid = 1'b1;
                            nstate = READY;
                        end
                    end
                end
                READY: begin
                    if (!Stall) begin
                        npc    = PCSrc ? (PCTarget & 32'hFFFF_FFFC) : PCPlus4;
                        ninstr = NOP_INSTR;
                        nvalid = 1'b0;
                        nstate = FETCH;
                    end
                end
                default: nstate = FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch; the bench plays instruction memory.
module tb_instr_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic        PCSrc;
    logic [31:0] PCTarget;
    logic        Stall;
    logic        Flush;
    logic [31:0] FlushPC;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic [31:0] Instr;
    logic        InstrValid;

    int checks;
    int failures;

    instr_fetch_if imem ();

    instr_fetch #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (NOP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .PCSrc      (PCSrc),
        .PCTarget   (PCTarget),
        .Stall      (Stall),
        .Flush      (Flush),
        .FlushPC    (FlushPC),
        .imem       (imem.master),
        .PC         (PC),
        .PCPlus4    (PCPlus4),
        .Instr      (Instr),
        .InstrValid (InstrValid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // From FETCH: grant now, return data one cycle later; ends in READY.
    task automatic fetch(input logic [31:0] data);
        imem.ImemGnt = 1'b1;
        step();
        imem.ImemGnt    = 1'b0;
        imem.ImemRValid = 1'b1;
        imem.ImemRData  = data;
        step();
        imem.ImemRValid = 1'b0;
        imem.ImemRData  = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++;
        if (InstrValid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", InstrValid); end
        checks++;
        if (Instr !== NOP) begin failures++; $display("FAIL reset_instr got=%h exp=%h", Instr, NOP); end
        checks++;
        if (PC !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0", PC); end
        reset = 1'b0;
        checks++;
        if (imem.ImemReq !== 1'b1 || imem.ImemAddr !== 32'h0) begin
            failures++; $display("FAIL reset_req got req=%b addr=%h exp req=1 addr=0", imem.ImemReq, imem.ImemAddr);
        end
    endtask

    task automatic test_basic();
        imem.ImemGnt = 1'b1;
        step();
        imem.ImemGnt    = 1'b0;
        imem.ImemRValid = 1'b1;
        imem.ImemRData  = 32'h0050_0093;
        checks++;
        if (imem.ImemReq !== 1'b0) begin failures++; $display("FAIL basic_wait_req got=%b exp=0", imem.ImemReq); end
        step();
        imem.ImemRValid = 1'b0;
        checks++;
        if (InstrValid !== 1'b1 || Instr !== 32'h0050_0093) begin
            failures++; $display("FAIL basic_instr got v=%b i=%h exp v=1 i=00500093", InstrValid, Instr);
        end
        checks++;
        if (PC !== 32'h0 || PCPlus4 !== 32'h4) begin
            failures++; $display("FAIL basic_pc got pc=%h p4=%h exp pc=0 p4=4", PC, PCPlus4);
        end
        step();
        checks++;
        if (imem.ImemReq !== 1'b1 || imem.ImemAddr !== 32'h4 || InstrValid !== 1'b0) begin
            failures++; $display("FAIL basic_retire got req=%b addr=%h v=%b exp req=1 addr=4 v=0",
                                 imem.ImemReq, imem.ImemAddr, InstrValid);
        end
    endtask

    task automatic test_branch();
        PCSrc    = 1'b1;
        PCTarget = 32'h0000_0103;
        fetch(32'h00A0_0113);
        checks++;
        if (InstrValid !== 1'b1 || PC !== 32'h4) begin
            failures++; $display("FAIL branch_ready got v=%b pc=%h exp v=1 pc=4", InstrValid, PC);
        end
        step();
        PCSrc = 1'b0;
        checks++;
        if (imem.ImemAddr !== 32'h0000_0100) begin
            failures++; $display("FAIL branch_target got=%h exp=00000100", imem.ImemAddr);
        end
    endtask

    task automatic test_gnt_wait();
        imem.ImemGnt = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (imem.ImemReq !== 1'b1 || imem.ImemAddr !== 32'h100 || InstrValid !== 1'b0 || Instr !== NOP) begin
                failures++; $display("FAIL gnt_wait[%0d] got req=%b addr=%h v=%b i=%h exp req=1 addr=100 v=0 i=%h",
                                     i, imem.ImemReq, imem.ImemAddr, InstrValid, Instr, NOP);
            end
        end
    endtask

    task automatic test_stall();
        Stall = 1'b1;
        fetch(32'h0020_8193);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (PC !== 32'h100 || Instr !== 32'h0020_8193 || InstrValid !== 1'b1) begin
                failures++; $display("FAIL stall_hold[%0d] got pc=%h i=%h v=%b exp pc=100 i=00208193 v=1",
                                     i, PC, Instr, InstrValid);
            end
            step();
        end
        Stall = 1'b0;
        checks++;
        if (PC !== 32'h100 || InstrValid !== 1'b1) begin
            failures++; $display("FAIL stall_last got pc=%h v=%b exp pc=100 v=1", PC, InstrValid);
        end
        step();
        checks++;
        if (PC !== 32'h104 || InstrValid !== 1'b0) begin
            failures++; $display("FAIL stall_release got pc=%h v=%b exp pc=104 v=0", PC, InstrValid);
        end
    endtask

    task automatic test_flush();
        // Flush while waiting; the stale word arrives the cycle after.
        imem.ImemGnt = 1'b1;
        step();
        imem.ImemGnt = 1'b0;
        Flush   = 1'b1;
        FlushPC = 32'h0000_0080;
        step();
        Flush = 1'b0;
        imem.ImemRValid = 1'b1;
        imem.ImemRData  = 32'hDEAD_BEEF;
        checks++;
        if (imem.ImemReq !== 1'b0 || PC !== 32'h80 || InstrValid !== 1'b0) begin
            failures++; $display("FAIL flush_wait got req=%b pc=%h v=%b exp req=0 pc=80 v=0", imem.ImemReq, PC, InstrValid);
        end
        step();
        imem.ImemRValid = 1'b0;
        checks++;
        if (InstrValid !== 1'b0 || Instr !== NOP || imem.ImemReq !== 1'b1 || imem.ImemAddr !== 32'h80) begin
            failures++; $display("FAIL flush_drop got v=%b i=%h req=%b addr=%h exp v=0 i=%h req=1 addr=80",
                                 InstrValid, Instr, imem.ImemReq, imem.ImemAddr, NOP);
        end
        // Kill must be cleared: next response is real.
        Stall = 1'b1;
        fetch(32'h0010_0093);
        checks++;
        if (InstrValid !== 1'b1 || Instr !== 32'h0010_0093 || PC !== 32'h80) begin
            failures++; $display("FAIL flush_refetch got v=%b i=%h pc=%h exp v=1 i=00100093 pc=80", InstrValid, Instr, PC);
        end
        // Flush in READY overrides Stall; low bits masked.
        Flush   = 1'b1;
        FlushPC = 32'h0000_0203;
        step();
        Flush = 1'b0;
        Stall = 1'b0;
        checks++;
        if (PC !== 32'h200 || InstrValid !== 1'b0 || Instr !== NOP || imem.ImemReq !== 1'b1) begin
            failures++; $display("FAIL flush_ready got pc=%h v=%b i=%h req=%b exp pc=200 v=0 i=%h req=1",
                                 PC, InstrValid, Instr, imem.ImemReq, NOP);
        end
        // Flush and rvalid in the same WAIT cycle.
        imem.ImemGnt = 1'b1;
        step();
        imem.ImemGnt    = 1'b0;
        Flush           = 1'b1;
        FlushPC         = 32'h0000_0040;
        imem.ImemRValid = 1'b1;
        imem.ImemRData  = 32'hBAD0_0001;
        step();
        Flush = 1'b0;
        imem.ImemRValid = 1'b0;
        checks++;
        if (imem.ImemReq !== 1'b1 || imem.ImemAddr !== 32'h40 || InstrValid !== 1'b0) begin
            failures++; $display("FAIL flush_rvalid got req=%b addr=%h v=%b exp req=1 addr=40 v=0",
                                 imem.ImemReq, imem.ImemAddr, InstrValid);
        end
        // Grant coinciding with Flush in FETCH: request counts, response dropped.
        imem.ImemGnt = 1'b1;
        Flush        = 1'b1;
        FlushPC      = 32'h0000_0060;
        step();
        imem.ImemGnt = 1'b0;
        Flush        = 1'b0;
        checks++;
        if (imem.ImemReq !== 1'b0 || PC !== 32'h60) begin
            failures++; $display("FAIL flush_gnt got req=%b pc=%h exp req=0 pc=60", imem.ImemReq, PC);
        end
        imem.ImemRValid = 1'b1;
        imem.ImemRData  = 32'hBAD0_0002;
        step();
        imem.ImemRValid = 1'b0;
        checks++;
        if (InstrValid !== 1'b0 || Instr !== NOP || imem.ImemReq !== 1'b1 || imem.ImemAddr !== 32'h60) begin
            failures++; $display("FAIL flush_gnt_drop got v=%b i=%h req=%b addr=%h exp v=0 i=%h req=1 addr=60",
                                 InstrValid, Instr, imem.ImemReq, imem.ImemAddr, NOP);
        end
    endtask

    task automatic test_wrap_and_reset();
        Flush   = 1'b1;
        FlushPC = 32'hFFFF_FFFF;
        step();
        Flush = 1'b0;
        checks++;
        if (imem.ImemAddr !== 32'hFFFF_FFFC || PCPlus4 !== 32'h0) begin
            failures++; $display("FAIL wrap_pc got addr=%h p4=%h exp addr=fffffffc p4=0", imem.ImemAddr, PCPlus4);
        end
        fetch(32'h0030_0213);
        step();
        checks++;
        if (imem.ImemAddr !== 32'h0 || imem.ImemReq !== 1'b1) begin
            failures++; $display("FAIL wrap_retire got addr=%h req=%b exp addr=0 req=1", imem.ImemAddr, imem.ImemReq);
        end
        // Reset while a request is outstanding.
        imem.ImemGnt = 1'b1;
        step();
        imem.ImemGnt = 1'b0;
        fetch_pc_dummy();
        reset = 1'b1;
        #1;
        checks++;
        if (imem.ImemReq !== 1'b1 || PC !== 32'h0 || InstrValid !== 1'b0 || Instr !== NOP) begin
            failures++; $display("FAIL reset_async got req=%b pc=%h v=%b i=%h exp req=1 pc=0 v=0 i=%h",
                                 imem.ImemReq, PC, InstrValid, Instr, NOP);
        end
        step();
        reset = 1'b0;
        imem.ImemRValid = 1'b1;
        imem.ImemRData  = 32'hBAD0_0003;
        step();
        imem.ImemRValid = 1'b0;
        checks++;
        if (imem.ImemReq !== 1'b1 || InstrValid !== 1'b0 || Instr !== NOP) begin
            failures++; $display("FAIL stale_rvalid got req=%b v=%b i=%h exp req=1 v=0 i=%h",
                                 imem.ImemReq, InstrValid, Instr, NOP);
        end
    endtask

    // Confirms the DUT is in WAIT (request dropped) before reset is applied.
    task automatic fetch_pc_dummy();
        checks++;
        if (imem.ImemReq !== 1'b0 || PC !== 32'h0) begin
            failures++; $display("FAIL pre_reset_wait got req=%b pc=%h exp req=0 pc=0", imem.ImemReq, PC);
        end
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        reset           = 1'b0;
        PCSrc           = 1'b0;
        PCTarget        = '0;
        Stall           = 1'b0;
        Flush           = 1'b0;
        FlushPC         = '0;
        imem.ImemGnt    = 1'b0;
        imem.ImemRValid = 1'b0;
        imem.ImemRData  = '0;
        #2;
        test_reset();
        test_basic();
        test_branch();
        test_gnt_wait();
        test_stall();
        test_flush();
        test_wrap_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
